// File: rtl/wallace_mac_accumulator.sv
// Streaming MAC wrapper around an external 8x8 Wallace multiplier: registers operands,
// cuts the product path, accumulates per frame and hands the frame result downstream.
module wallace_mac_accumulator #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [16:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  typedef enum logic [1:0] {StAccum, StDrain, StHold} state_e;

  state_e state_q, state_d;

  logic             in_xfer, out_xfer;
  logic [7:0]       mul_a_q, mul_b_q;
  logic             v1_q, last1_q;
  logic [16:0]      p2_q;
  logic             v2_q, last2_q;
  logic [ACC_W-1:0] acc_q, acc_new;
  logic [ACC_W:0]   sum_wide;
  logic [CNT_W-1:0] cnt_q, cnt_new;
  logic             ovf_q, ovf_new;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             out_ovf_q;

  assign in_ready  = (state_q == StAccum);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (in_xfer && in_last) state_d = StDrain;
      StDrain: if (v2_q && last2_q) state_d = StHold;
      StHold:  if (out_xfer) state_d = StAccum;
      default: state_d = StAccum;
    endcase
  end

  // Carry out of the widened add means the accumulator would wrap; clamp instead.
  always_comb begin
    sum_wide = {1'b0, acc_q} + {{(ACC_W - 16){1'b0}}, p2_q};
    acc_new  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    ovf_new  = ovf_q | sum_wide[ACC_W];
    cnt_new  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAccum;
      mul_a_q <= '0;
      mul_b_q <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      p2_q    <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q    <= in_xfer;
      last1_q <= in_xfer && in_last;
      if (in_xfer) begin
        mul_a_q <= in_a;
        mul_b_q <= in_b;
      end
      v2_q    <= v1_q;
      last2_q <= last1_q;
      if (v1_q) p2_q <= mul_p;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (out_xfer) out_valid_q <= 1'b0;
      if (v2_q) begin
        if (last2_q) begin
          // Publish the frame including this product and start the next frame from zero.
          out_sum_q   <= acc_new;
          out_cnt_q   <= cnt_new;
          out_ovf_q   <= ovf_new;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
        end else begin
          acc_q <= acc_new;
          cnt_q <= cnt_new;
          ovf_q <= ovf_new;
        end
      end
    end
  end

endmodule
